// File: rtl/y86_pkg.sv
// y86_pkg: constants shared by the Y86 register file and its users.
//   DATA_WID / ADDR_WID : default data and register-id widths.
//   RNONE               : "no register" id (all ones).
//   RRAX..R14           : architectural register ids (RRSP is the stack pointer).
package y86_pkg;
  localparam int DATA_WID = 64;
  localparam int ADDR_WID = 4;

  localparam logic [3:0] RRAX  = 4'h0;
  localparam logic [3:0] RRCX  = 4'h1;
  localparam logic [3:0] RRDX  = 4'h2;
  localparam logic [3:0] RRBX  = 4'h3;
  localparam logic [3:0] RRSP  = 4'h4;
  localparam logic [3:0] RRBP  = 4'h5;
  localparam logic [3:0] RRSI  = 4'h6;
  localparam logic [3:0] RRDI  = 4'h7;
  localparam logic [3:0] RR8   = 4'h8;
  localparam logic [3:0] RR9   = 4'h9;
  localparam logic [3:0] RR10  = 4'hA;
  localparam logic [3:0] RR11  = 4'hB;
  localparam logic [3:0] RR12  = 4'hC;
  localparam logic [3:0] RR13  = 4'hD;
  localparam logic [3:0] RR14  = 4'hE;
  localparam logic [3:0] RNONE = 4'hF;
endpackage

// File: rtl/regfile_scoreboard_if.sv
// regfile_scoreboard_if: bundle between decode/writeback (master) and the
// register file (slave).
//   srcA/srcB -> valA/valB, busyA/busyB : read ports and hazard flags
//   destE/destM + valE/valM            : writeback ports
//   claim_en + claimE/claimM           : destination claims at issue
//   claim_err                          : sticky claim-overflow flag
// Handshake: there is no valid/ready pair. A write is qualified by its id
// (RNONE = idle), a claim by claim_en plus its id (RNONE = nothing claimed);
// every qualified event is accepted on the rising edge it is presented at.
interface regfile_scoreboard_if #(
  parameter int DATA_WID = 64,
  parameter int ADDR_WID = 4
);
  logic [ADDR_WID-1:0] srcA, srcB;
  logic [DATA_WID-1:0] valA, valB;
  logic                busyA, busyB;
  logic [ADDR_WID-1:0] destE, destM;
  logic [DATA_WID-1:0] valE, valM;
  logic                claim_en;
  logic [ADDR_WID-1:0] claimE, claimM;
  logic                claim_err;

  modport master (
    output srcA, srcB, destE, destM, valE, valM, claim_en, claimE, claimM,
    input  valA, valB, busyA, busyB, claim_err
  );

  modport slave (
    input  srcA, srcB, destE, destM, valE, valM, claim_en, claimE, claimM,
    output valA, valB, busyA, busyB, claim_err
  );
endinterface

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register pending-write counters.
//   CLK, RST         : clock, synchronous active-high reset
//   claim_en/claimE/claimM : issue-time claims (increment)
//   destE/destM      : writeback releases (decrement)
//   count            : current pending count of every register
//   claim_err        : sticky, set when a claim hits a saturated counter
module reg_scoreboard #(
  parameter int ADDR_WID = 4,
  parameter int NREG     = 15,
  parameter int CNT_WID  = 2
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                claim_en,
  input  logic [ADDR_WID-1:0] claimE,
  input  logic [ADDR_WID-1:0] claimM,
  input  logic [ADDR_WID-1:0] destE,
  input  logic [ADDR_WID-1:0] destM,
  output logic [CNT_WID-1:0]  count [NREG],
  output logic                claim_err
);
  localparam logic [CNT_WID-1:0] CNT_MAX = '1;

  logic [NREG-1:0] inc;
  logic [NREG-1:0] dec;

  // A register named on both ports of a claim or of a writeback counts once.
  always_comb begin
    inc = '0;
    dec = '0;
    for (int r = 0; r < NREG; r++) begin
      inc[r] = claim_en && ((claimE == ADDR_WID'(r)) || (claimM == ADDR_WID'(r)));
      dec[r] = (destE == ADDR_WID'(r)) || (destM == ADDR_WID'(r));
    end
  end

  // Claim and release together leave the count unchanged, even at 0 or max.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int r = 0; r < NREG; r++) count[r] <= '0;
      claim_err <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        case ({inc[r], dec[r]})
          2'b10: begin
            if (count[r] == CNT_MAX) claim_err <= 1'b1;
            else                     count[r]  <= count[r] + CNT_WID'(1);
          end
          2'b01: begin
            if (count[r] != '0) count[r] <= count[r] - CNT_WID'(1);
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: Y86 register file with two combinational read ports,
// two clocked write ports (E, M; M wins on a shared id), same-cycle
// write-to-read bypass and a pending-write scoreboard driving busyA/busyB.
//   CLK, RST : clock, synchronous active-high reset
//   rf       : slave side of regfile_scoreboard_if (reads, writes, claims)
// Ids >= NREG (including RNONE) read as 0, are never busy and are not written.
// NREG must be below 2**ADDR_WID so that RNONE never aliases a real register.
module regfile_scoreboard #(
  parameter int DATA_WID = y86_pkg::DATA_WID,
  parameter int ADDR_WID = y86_pkg::ADDR_WID,
  parameter int NREG     = 15,
  parameter int CNT_WID  = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  regfile_scoreboard_if.slave  rf
);
  import y86_pkg::*;

  logic [DATA_WID-1:0] regs  [NREG];
  logic [CNT_WID-1:0]  count [NREG];
  logic                claim_err_q;

  reg_scoreboard #(
    .ADDR_WID (ADDR_WID),
    .NREG     (NREG),
    .CNT_WID  (CNT_WID)
  ) u_sb (
    .CLK       (CLK),
    .RST       (RST),
    .claim_en  (rf.claim_en),
    .claimE    (rf.claimE),
    .claimM    (rf.claimM),
    .destE     (rf.destE),
    .destM     (rf.destM),
    .count     (count),
    .claim_err (claim_err_q)
  );

  assign rf.claim_err = claim_err_q;

  // M is checked first so a dual write to one id keeps valM.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (rf.destM == ADDR_WID'(r))      regs[r] <= rf.valM;
        else if (rf.destE == ADDR_WID'(r)) regs[r] <= rf.valE;
      end
    end
  end

  logic                hit_a, hit_b;
  logic [CNT_WID-1:0]  cnt_a, cnt_b;
  logic [DATA_WID-1:0] arr_a, arr_b;

  // Array lookup by scan: an id that matches no register leaves hit low,
  // which covers both RNONE and out-of-range ids.
  always_comb begin
    hit_a = 1'b0;
    hit_b = 1'b0;
    cnt_a = '0;
    cnt_b = '0;
    arr_a = '0;
    arr_b = '0;
    for (int r = 0; r < NREG; r++) begin
      if (rf.srcA == ADDR_WID'(r)) begin
        hit_a = 1'b1;
        cnt_a = count[r];
        arr_a = regs[r];
      end
      if (rf.srcB == ADDR_WID'(r)) begin
        hit_b = 1'b1;
        cnt_b = count[r];
        arr_b = regs[r];
      end
    end
  end

  always_comb begin
    rf.valA = '0;
    if (hit_a) begin
      if (rf.srcA == rf.destM)      rf.valA = rf.valM;
      else if (rf.srcA == rf.destE) rf.valA = rf.valE;
      else                          rf.valA = arr_a;
    end
    rf.valB = '0;
    if (hit_b) begin
      if (rf.srcB == rf.destM)      rf.valB = rf.valM;
      else if (rf.srcB == rf.destE) rf.valB = rf.valE;
      else                          rf.valB = arr_b;
    end
  end

  // The last outstanding write retiring this cycle is covered by the bypass,
  // so it no longer counts as a hazard.
  always_comb begin
    rf.busyA = hit_a && (cnt_a != '0) &&
               !((cnt_a == CNT_WID'(1)) && ((rf.srcA == rf.destE) || (rf.srcA == rf.destM)));
    rf.busyB = hit_b && (cnt_b != '0) &&
               !((cnt_b == CNT_WID'(1)) && ((rf.srcB == rf.destE) || (rf.srcB == rf.destM)));
  end
endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised Y86 register file for the pipelined core: two combinational read ports, two clocked write ports (E and M), same-cycle write-to-read bypass, synchronous reset of all registers, and a per-register pending-write scoreboard. Decode claims destinations at issue and writeback releases them. The block raises `busyA` / `busyB` so the hazard unit can stall decode when a source register is still in flight. It sits between decode (`srcA`/`srcB`, claims) and writeback (`destE`/`destM`).

## Interface
- `DATA_WID`, 64: register width in bits.
- `ADDR_WID`, 4: register-id width.
- `NREG`, 15: number of architectural registers (ids 0..NREG-1). Id `RNONE` (all ones) means "no register".
- `CNT_WID`, 2: pending-count width per register. Maximum in-flight writes per register = 2^CNT_WID-1.

- `CLK`  in  1: clock; all state updates on the rising edge.
- `RST`  in  1: synchronous, active-high reset.
- `srcA`, `srcB`  in  ADDR_WID: read register ids.
- `valA`, `valB`  out  DATA_WID: read data.
- `busyA`, `busyB`  out  1: source has a pending write.
- `destE`, `destM`  in  ADDR_WID: write ids; `RNONE` disables the port.
- `valE`, `valM`  in  DATA_WID: write data.
- `claim_en`  in  1: an instruction issues this cycle.
- `claimE`, `claimM`  in  ADDR_WID: destinations claimed at issue; `RNONE` claims nothing.
- `claim_err`  out  1: sticky flag, set on a claim to a saturated counter.

## Operation
- **Read (combinational).** Priority per port, highest first:
  - src == `RNONE` or src ≥ NREG: return 0.
  - src == `destM`: return `valM`.
  - src == `destE`: return `valE`.
  - Otherwise return the array entry.
  - M over E mirrors the write rule below.
- **Write.** At the edge, `reg[destE] <= valE` and `reg[destM] <= valM`.
  - If `destE == destM` (not `RNONE`), `valM` wins (popq %rsp semantics).
  - Ids ≥ NREG other than `RNONE` are ignored.
- **Scoreboard.** For each register r:
  - inc = `claim_en` and (`claimE`==r or `claimM`==r); a register claimed on both ports counts once.
  - dec = (`destE`==r) + (`destM`==r), capped at 1, so a dual write to one register releases once.
  - next count = count + inc − dec.
  - Decrement at count 0 is suppressed; the write still happens.
  - Increment at count max is suppressed and sets `claim_err`.
- **Busy flags.** `busyX` = (`count[srcX]` ≠ 0) and srcX ≠ `RNONE`, with one exception: a source whose count is exactly 1 and is being released this cycle reads as not busy, because the bypass supplies the data.
- **Reset.** While `RST` is high, all registers go to 0, all counts go to 0 and `claim_err` goes to 0. Writes and claims in that cycle are ignored. Reset wins over any simultaneous event.

## Timing
- Read latency: 0 cycles (combinational from `src*`, `dest*`, `val*`).
- Write latency: 1 edge. The value is visible through the array the cycle after, and through the bypass in the same cycle.
- Claim to busy: the `busyX` rise is visible the cycle after the claim edge.
- Release to clear: `busyX` drops combinationally in the release cycle (count 1 case).
- Claim and release of the same register in the same cycle: count unchanged.
- Reset values of outputs after the `RST` edge:
  - `valA` = `valB` = 0 (absent bypass).
  - `busyA` = `busyB` = 0.
  - `claim_err` = 0.

## Structure
- Shared package `y86_pkg`: `DATA_WID`, `ADDR_WID`, `RNONE` = 4'hF, `RRSP` = 4'h4, and the register-id constants.
- Sub-module `reg_scoreboard`:
  - Holds the counter array, the inc/dec logic, saturation and `claim_err`.
  - Outputs the per-register counts to the top.
- Top level `regfile_scoreboard` holds the data array, the write-priority logic, the bypass muxes and the busy gating.

## Test plan
- **Reset then read.** Reset, then read ids 0..14 → all `valA`/`valB` = 0, `busy*` = 0.
- **Write, dual write, bypass.**
  - `destE`=3, `valE`=0x11, `destM`=`RNONE` → next cycle `srcA`=3 reads 0x11.
  - `destE`=`destM`=4, `valE`=0xAA, `valM`=0xBB → reg 4 = 0xBB.
  - In that same cycle, `srcB`=4 reads 0xBB via bypass.
- **Scoreboard hazard.**
  - Claim `claimE`=2; next cycle `srcA`=2 → `busyA`=1.
  - Writeback `destE`=2 → `busyA`=0 in the same cycle and `valA`=`valE`.
- **Multiple in flight.**
  - Claim reg 5 three times → count 3; a fourth claim → `claim_err`=1 (sticky), count stays 3.
  - Three releases → `busy` clears only on the third.
- **Simultaneous events.**
  - Claim and release reg 6 in one cycle from count 1 → count stays 1, `busy` persists.
  - Release at count 0 → count 0, data written.
- **Reset mid-operation.** Counts nonzero and `claim_err`=1, assert `RST` together with a write to reg 7 → all counts 0, `claim_err`=0, reg 7 = 0.
